muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set operand, HI and LO width; legal values are 8..64.
REQ-002 Parameter CNT_W, default $clog2(WIDTH)+1, SHALL set the iteration counter width.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port op_valid_i, input, 1 bit: operation request.
REQ-006 Port op_i, input, 3 bits: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6..7 reserved.
REQ-007 Port rs_i, input, WIDTH: operand A / dividend / MTHI-MTLO source.
REQ-008 Port rt_i, input, WIDTH: operand B / divisor.
REQ-009 Port op_ready_o, output, 1 bit: high when a request is accepted this cycle.
REQ-010 Port busy_o, output, 1 bit: an arithmetic operation is in progress.
REQ-011 Port done_o, output, 1 bit: one-cycle pulse marking HI/LO update by an arithmetic op.
REQ-012 Port hi_o, output, WIDTH: HI register.
REQ-013 Port lo_o, output, WIDTH: LO register.

Function
REQ-014 The FSM SHALL have states IDLE, CALC and FIXUP; busy_o is high when state is not IDLE.
REQ-015 op_ready_o SHALL equal NOT busy_o; a request is accepted on an edge where op_valid_i and op_ready_o are both high.
REQ-016 A request while busy SHALL be ignored and SHALL leave HI, LO and the FSM unaffected.
REQ-017 Reserved op_i codes SHALL be accepted with no effect.
REQ-018 Accepted MTHI/MTLO SHALL write rs_i into HI/LO at that edge, stay IDLE, and not pulse done_o.
REQ-019 Accepted MULT/MULTU/DIV/DIVU SHALL latch operands: magnitudes for signed ops, raw values for unsigned ops, plus the result signs.
REQ-020 Accepted MULT/MULTU/DIV/DIVU SHALL move the FSM to CALC, except as stated in REQ-024.
REQ-021 CALC SHALL run exactly WIDTH cycles, one bit per cycle, with shift-add multiply and restoring division on unsigned magnitudes.
REQ-022 CALC SHALL then move to FIXUP.
REQ-023 FIXUP SHALL last 1 cycle: apply sign correction, write HI/LO at its closing edge, return to IDLE, and register done_o high for the following cycle.
REQ-024 A divisor of zero in DIV/DIVU SHALL skip CALC, go directly to FIXUP, and write HI=0 and LO=0.
REQ-025 Latency: busy_o high for WIDTH+1 cycles, or 1 cycle for divide-by-zero; done_o in the cycle after busy_o falls; a new op is acceptable in that same cycle.
REQ-026 MULT/MULTU SHALL write the full 2*WIDTH product: HI = upper half, LO = lower half; signed product in two's complement.
REQ-027 DIV/DIVU SHALL write LO = quotient and HI = remainder.
REQ-028 Signed quotient SHALL truncate toward zero; signed remainder SHALL take the dividend's sign.
REQ-029 Signed DIV of the most-negative value by -1 SHALL give LO = most-negative value and HI = 0, with no error.
REQ-030 hi_o/lo_o SHALL hold the previous values throughout CALC; there are no partial updates.
REQ-031 Operand inputs SHALL be sampled only at acceptance; later changes SHALL NOT affect the result.

Reset
REQ-032 reset_i high SHALL immediately force state IDLE, HI=0, LO=0, done_o=0, busy_o=0, op_ready_o=1 and the iteration counter to 0.
REQ-033 Reset asserted mid-CALC or mid-FIXUP SHALL abort the operation with no HI/LO write and no done_o pulse.
REQ-034 Requests SHALL be ignored while reset_i is high; the first acceptance is at the first edge after deassertion.

Verification
REQ-035 WIDTH=32: MULT rs=0xFFFFFFFE (-2), rt=0x00000003 -> after 33 busy cycles, HI=0xFFFFFFFF, LO=0xFFFFFFFA, one done_o pulse.
REQ-036 WIDTH=32: DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU on the same operands -> LO=0x7FFFFFFC, HI=1.
REQ-037 WIDTH=32: DIVU rt=0 -> busy 1 cycle, HI=LO=0, done_o pulse; then DIV 0x80000000 by 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-038 WIDTH=32: MULTU 0xFFFFFFFF x 0xFFFFFFFF with MTLO 0x12345678 and a second MULT requested while busy -> HI=0xFFFFFFFE, LO=0x00000001, both busy-time requests ignored.
REQ-039 WIDTH=32: MTHI 0xAAAA5555 then MTLO 0x1 on back-to-back cycles -> HI=0xAAAA5555, LO=1, busy_o never high, done_o never high.
REQ-040 WIDTH=8: reset_i pulsed during CALC cycle 4 of MULT 0x7F x 0x7F -> HI=LO=0 and idle; re-issued op -> HI=0x3F, LO=0x01 after 9 busy cycles.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide run on unsigned magnitudes; signs are re-applied in FIXUP.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             op_valid_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  output logic             op_ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               is_div_q, is_div_d;
  logic               dz_q, dz_d;
  logic               neg_q, neg_d;
  logic               neg_rem_q, neg_rem_d;

  logic               op_signed;
  logic               op_div;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic               div_ge;
  logic [2*WIDTH-1:0] product;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  assign op_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
  assign op_div    = (op_i == OP_DIV)  || (op_i == OP_DIVU);

  // Multiply: {acc,sreg} shifts right, adding the multiplicand when the multiplier LSB is set.
  assign addend  = sreg_q[0] ? mcand_q : '0;
  assign mul_sum = {1'b0, acc_q} + {1'b0, addend};

  // Divide: remainder < divisor, so the trial difference's top bit is exactly its sign.
  assign div_shift = {acc_q, sreg_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, mcand_q};
  assign div_ge    = ~div_trial[WIDTH];

  assign product = cond_neg2({acc_q, sreg_q}, neg_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    acc_d     = acc_q;
    sreg_d    = sreg_q;
    mcand_d   = mcand_q;
    is_div_d  = is_div_q;
    dz_d      = dz_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    case (state_q)
      IDLE: begin
        if (op_valid_i) begin
          case (op_i)
            OP_MTHI: hi_d = rs_i;
            OP_MTLO: lo_d = rs_i;
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              is_div_d  = op_div;
              dz_d      = op_div && (rt_i == '0);
              neg_d     = op_signed && (rs_i[WIDTH-1] ^ rt_i[WIDTH-1]);
              neg_rem_d = op_signed && rs_i[WIDTH-1];
              sreg_d    = mag(rs_i, op_signed);
              mcand_d   = mag(rt_i, op_signed);
              acc_d     = '0;
              cnt_d     = '0;
              state_d   = (op_div && (rt_i == '0)) ? FIXUP : CALC;
            end
            default: ;
          endcase
        end
      end
      CALC: begin
        if (is_div_q) begin
          acc_d  = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
          sreg_d = {sreg_q[WIDTH-2:0], div_ge};
        end else begin
          acc_d  = mul_sum[WIDTH:1];
          sreg_d = {mul_sum[0], sreg_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIXUP;
      end
      FIXUP: begin
        if (dz_q) begin
          hi_d = '0;
          lo_d = '0;
        end else if (is_div_q) begin
          lo_d = cond_neg(sreg_q, neg_q);
          hi_d = cond_neg(acc_q, neg_rem_q);
        end else begin
          hi_d = product[2*WIDTH-1:WIDTH];
          lo_d = product[WIDTH-1:0];
        end
        cnt_d   = '0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // Datapath working registers carry no reset; they are reloaded on every accepted op.
  always_ff @(posedge clk) begin
    acc_q     <= acc_d;
    sreg_q    <= sreg_d;
    mcand_q   <= mcand_d;
    is_div_q  <= is_div_d;
    dz_q      <= dz_d;
    neg_q     <= neg_d;
    neg_rem_q <= neg_rem_d;
  end

  assign busy_o     = (state_q != IDLE);
  assign op_ready_o = (state_q == IDLE);
  assign done_o     = done_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: vector table, corner-case sequences and random ops against an arithmetic model.
// A second 8-bit instance covers the mid-operation reset case.
module tb_muldiv_unit;

  logic        clk;
  logic        rst32, vld32, ready32, busy32, done32;
  logic [2:0]  op32;
  logic [31:0] rs32, rt32, hi32, lo32;
  logic        rst8, vld8, ready8, busy8, done8;
  logic [2:0]  op8;
  logic [7:0]  rs8, rt8, hi8, lo8;

  int checks = 0;
  int errors = 0;
  logic [31:0] mhi, mlo;

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset_i(rst32), .op_valid_i(vld32), .op_i(op32), .rs_i(rs32), .rt_i(rt32),
    .op_ready_o(ready32), .busy_o(busy32), .done_o(done32), .hi_o(hi32), .lo_o(lo32)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_i(rst8), .op_valid_i(vld8), .op_i(op8), .rs_i(rs8), .rt_i(rt8),
    .op_ready_o(ready8), .busy_o(busy8), .done_o(done8), .hi_o(hi8), .lo_o(lo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    string       nm;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          busy;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Arithmetic reference: results straight from 64-bit integer math.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] h, inout logic [31:0] l, output int busy);
    longint      sa, sb, sq, sr;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    busy = 0;
    case (op)
      3'd0: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; busy = 33; end
      3'd1: begin p = ua * ub; h = p[63:32]; l = p[31:0]; busy = 33; end
      3'd2: begin
        if (b == 32'd0) begin h = '0; l = '0; busy = 1; end
        else begin sq = sa / sb; sr = sa % sb; l = sq[31:0]; h = sr[31:0]; busy = 33; end
      end
      3'd3: begin
        if (b == 32'd0) begin h = '0; l = '0; busy = 1; end
        else begin p = ua / ub; l = p[31:0]; p = ua % ub; h = p[31:0]; busy = 33; end
      end
      3'd4: h = a;
      3'd5: l = a;
      default: ;
    endcase
  endtask

  task automatic run_check(input string nm, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                           input int eb);
    int bc;
    int early_done;
    @(negedge clk);
    vld32 = 1'b1; op32 = op; rs32 = a; rt32 = b;
    @(negedge clk);
    vld32 = 1'b0; op32 = 3'($urandom); rs32 = $urandom; rt32 = $urandom;
    bc = 0;
    early_done = 0;
    while (busy32 && bc < 200) begin
      if (done32) early_done++;
      bc++;
      @(negedge clk);
    end
    chk({nm, " busy_cycles"}, 64'(bc), 64'(eb));
    chk({nm, " early_done"}, 64'(early_done), 64'd0);
    chk({nm, " done"}, {63'b0, done32}, (eb > 0) ? 64'd1 : 64'd0);
    chk({nm, " hi"}, {32'b0, hi32}, {32'b0, eh});
    chk({nm, " lo"}, {32'b0, lo32}, {32'b0, el});
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb, reh, rel;
    int          reb;
    int          bc;
    int          bad;

    vecs[0] = '{"mult_neg2x3",   3'd0, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 33};
    vecs[1] = '{"div_m7_2",      3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[2] = '{"divu_m7_2",     3'd3, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 33};
    vecs[3] = '{"divu_by0",      3'd3, 32'h00001234, 32'h00000000, 32'h00000000, 32'h00000000, 1};
    vecs[4] = '{"div_min_m1",    3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    vecs[5] = '{"multu_max",     3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
    vecs[6] = '{"mult_min_min",  3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33};
    vecs[7] = '{"div_7_m2",      3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
    vecs[8] = '{"div_by0",       3'd2, 32'hFFFFFFF9, 32'h00000000, 32'h00000000, 32'h00000000, 1};

    // Reset state, with a request held during reset
    rst32 = 1'b1; vld32 = 1'b1; op32 = 3'd4; rs32 = 32'hFFFFFFFF; rt32 = '0;
    rst8 = 1'b1; vld8 = 1'b0; op8 = '0; rs8 = '0; rt8 = '0;
    repeat (3) @(negedge clk);
    chk("reset hi", {32'b0, hi32}, 64'd0);
    chk("reset lo", {32'b0, lo32}, 64'd0);
    chk("reset busy", {63'b0, busy32}, 64'd0);
    chk("reset ready", {63'b0, ready32}, 64'd1);
    chk("reset done", {63'b0, done32}, 64'd0);
    rst32 = 1'b0; rst8 = 1'b0; rs32 = 32'hCAFEF00D;
    @(negedge clk);
    vld32 = 1'b0;
    chk("first accept hi", {32'b0, hi32}, 64'hCAFEF00D);
    mhi = 32'hCAFEF00D; mlo = '0;

    for (int i = 0; i < 9; i++) begin
      run_check(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].busy);
      mhi = vecs[i].hi; mlo = vecs[i].lo;
    end

    run_check("reserved6", 3'd6, 32'h11111111, 32'h2, mhi, mlo, 0);
    run_check("reserved7", 3'd7, 32'h22222222, 32'h3, mhi, mlo, 0);

    // MTHI then MTLO on back-to-back cycles
    @(negedge clk);
    vld32 = 1'b1; op32 = 3'd4; rs32 = 32'hAAAA5555;
    @(negedge clk);
    chk("mthi busy", {63'b0, busy32}, 64'd0);
    chk("mthi hi", {32'b0, hi32}, 64'hAAAA5555);
    op32 = 3'd5; rs32 = 32'h00000001;
    @(negedge clk);
    vld32 = 1'b0;
    chk("mtlo busy", {63'b0, busy32}, 64'd0);
    chk("mtlo done", {63'b0, done32}, 64'd0);
    chk("mtlo hi", {32'b0, hi32}, 64'hAAAA5555);
    chk("mtlo lo", {32'b0, lo32}, 64'h1);
    mhi = 32'hAAAA5555; mlo = 32'h1;

    // MULTU with MTLO and MULT requested while busy
    @(negedge clk);
    vld32 = 1'b1; op32 = 3'd1; rs32 = 32'hFFFFFFFF; rt32 = 32'hFFFFFFFF;
    @(negedge clk);
    vld32 = 1'b0;
    bc = 0;
    while (busy32 && bc < 200) begin
      if (bc == 3) begin vld32 = 1'b1; op32 = 3'd5; rs32 = 32'h12345678; end
      else if (bc == 4) begin vld32 = 1'b1; op32 = 3'd0; rs32 = 32'd5; rt32 = 32'd7; end
      else vld32 = 1'b0;
      if (bc == 10) begin
        chk("busy ready", {63'b0, ready32}, 64'd0);
        chk("calc hold hi", {32'b0, hi32}, {32'b0, mhi});
        chk("calc hold lo", {32'b0, lo32}, {32'b0, mlo});
      end
      bc++;
      @(negedge clk);
    end
    vld32 = 1'b0;
    chk("busyreq busy_cycles", 64'(bc), 64'd33);
    chk("busyreq done", {63'b0, done32}, 64'd1);
    chk("busyreq hi", {32'b0, hi32}, 64'hFFFFFFFE);
    chk("busyreq lo", {32'b0, lo32}, 64'h00000001);
    @(negedge clk);
    chk("busyreq no restart", {63'b0, busy32}, 64'd0);
    chk("done one pulse", {63'b0, done32}, 64'd0);
    mhi = 32'hFFFFFFFE; mlo = 32'h1;

    // 8-bit instance: reset during CALC cycle 4, then re-issue
    @(negedge clk);
    vld8 = 1'b1; op8 = 3'd4; rs8 = 8'h55;
    @(negedge clk);
    op8 = 3'd5; rs8 = 8'hAA;
    @(negedge clk);
    op8 = 3'd0; rs8 = 8'h7F; rt8 = 8'h7F;
    chk("w8 preload", {48'b0, hi8, lo8}, 64'h55AA);
    @(negedge clk);
    vld8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("w8 in calc", {63'b0, busy8}, 64'd1);
    rst8 = 1'b1;
    #1;
    chk("w8 async busy", {63'b0, busy8}, 64'd0);
    chk("w8 async ready", {63'b0, ready8}, 64'd1);
    chk("w8 async hilo", {48'b0, hi8, lo8}, 64'd0);
    @(negedge clk);
    rst8 = 1'b0;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8 || hi8 != 8'd0 || lo8 != 8'd0) bad++;
    end
    chk("w8 abort quiet", 64'(bad), 64'd0);
    vld8 = 1'b1; op8 = 3'd0; rs8 = 8'h7F; rt8 = 8'h7F;
    @(negedge clk);
    vld8 = 1'b0; rs8 = 8'h01; rt8 = 8'h80;
    bc = 0;
    while (busy8 && bc < 100) begin
      bc++;
      @(negedge clk);
    end
    chk("w8 busy_cycles", 64'(bc), 64'd9);
    chk("w8 done", {63'b0, done8}, 64'd1);
    chk("w8 hi", {56'b0, hi8}, 64'h3F);
    chk("w8 lo", {56'b0, lo8}, 64'h01);

    // Random ops against the arithmetic model
    for (int i = 0; i < 150; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        3: ra = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      reh = mhi; rel = mlo;
      model(rop, ra, rb, reh, rel, reb);
      run_check("rand", rop, ra, rb, reh, rel, reb);
      mhi = reh; mlo = rel;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
